// File: rtl/kuz_pkg.sv
// Shared types, constants and GF(2^8) helper for the Kuznyechik inverse linear layer.
package kuz_pkg;

   typedef logic [127:0] block_t;

   typedef enum logic [1:0] {
      KUZ_IDLE,
      KUZ_BUSY,
      KUZ_DONE
   } kuz_state_t;

   localparam logic [7:0] KUZ_POLY = 8'hC3;

   // Index 15 holds c15, so the coefficient index matches the byte position.
   localparam logic [15:0][7:0] KUZ_L_COEF = {
      8'd148, 8'd32,  8'd133, 8'd16,  8'd194, 8'd192, 8'd1,   8'd251,
      8'd1,   8'd192, 8'd194, 8'd16,  8'd133, 8'd32,  8'd148, 8'd1
   };

   // Shift-and-add multiply; with a constant operand this folds to xtime/XOR logic.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      acc = '0;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ x;
         x = x[7] ? ((x << 1) ^ KUZ_POLY) : (x << 1);
      end
      return acc;
   endfunction

endpackage

// File: rtl/kuz_r_inv_step.sv
// One combinational R^-1 step: left byte shift with l() of the rotated block appended as a0.
module kuz_r_inv_step
   import kuz_pkg::*;
(
   input  block_t i_block,
   output block_t o_block
);

   logic [15:0][7:0] w_b;
   logic [7:0]       w_l;

   // l() sees a14..a0 followed by a15, i.e. the block rotated left by one byte.
   assign w_b = {i_block[119:0], i_block[127:120]};

   always_comb begin
      w_l = '0;
      for (int i = 0; i < 16; i++) begin
         w_l = w_l ^ gf_mul(w_b[i], KUZ_L_COEF[i]);
      end
   end

   assign o_block = {i_block[119:0], w_l};

endmodule

// File: rtl/l_conversion_revers.sv
// Iterative L^-1 for Kuznyechik decryption: STEPS_PER_CYCLE chained R^-1 steps per clock,
// one block in flight, valid/ready on both sides.
module l_conversion_revers
   import kuz_pkg::*;
#(
   parameter int STEPS_PER_CYCLE = 1
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] input_bytes,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] output_bytes
);

   localparam int         N    = 16 / STEPS_PER_CYCLE;
   localparam logic [3:0] LAST = 4'(N - 1);

   kuz_state_t r_state;
   kuz_state_t w_next;
   block_t     r_work;
   block_t     r_out;
   logic [3:0] r_cnt;

   block_t w_chain [STEPS_PER_CYCLE + 1];

   assign w_chain[0] = r_work;

   for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
      kuz_r_inv_step u_step (
         .i_block (w_chain[g]),
         .o_block (w_chain[g + 1])
      );
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         KUZ_IDLE: if (in_valid)       w_next = KUZ_BUSY;
         KUZ_BUSY: if (r_cnt == LAST)  w_next = KUZ_DONE;
         KUZ_DONE: if (out_ready)      w_next = KUZ_IDLE;
         default:                      w_next = KUZ_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= KUZ_IDLE;
         r_work  <= '0;
         r_out   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            KUZ_IDLE: begin
               if (in_valid) begin
                  r_work <= input_bytes;
                  r_cnt  <= '0;
               end
            end
            KUZ_BUSY: begin
               r_work <= w_chain[STEPS_PER_CYCLE];
               r_cnt  <= r_cnt + 4'd1;
               if (r_cnt == LAST) r_out <= w_chain[STEPS_PER_CYCLE];
            end
            default: ;
         endcase
      end
   end

   assign in_ready     = (r_state == KUZ_IDLE);
   assign out_valid    = (r_state == KUZ_DONE);
   assign output_bytes = r_out;

endmodule
